// File: rtl/uart_rx_ext.sv
// uart_rx_ext: parametrised UART receiver with synchroniser, parity/framing/break detection and held output.
// Define UART_RX_MAJORITY_EN to sample with a 3-tick majority vote instead of a single rx_s sample.
module uart_rx_ext #(
    parameter int DBIT = 8,
    parameter int OVS = 16,
    parameter int PARITY = 0,
    parameter int SB = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    input  logic            rd,
    output logic [DBIT-1:0] rx_dout,
    output logic            rx_done_tick,
    output logic            rx_valid,
    output logic            parity_err,
    output logic            frame_err,
    output logic            break_det,
    output logic            overrun
);
    localparam int TW = $clog2(OVS) + 1;
    localparam int BW = $clog2(DBIT);
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
    state_t state;
    logic rx_m, rx_s, low_seen, par_acc, par_bit, perr_n, ferr_n;
    logic samp, hit, last_stop, ferr_f;
    logic [TW-1:0] tick;
    logic [BW-1:0] bcnt;
    logic [DBIT-1:0] data;
`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;
    always_ff @(posedge clk or posedge reset)
        if (reset) hist <= '1;
        else if (s_tick) hist <= {hist[0], rx_s};
    assign samp = (rx_s & hist[0]) | (rx_s & hist[1]) | (hist[0] & hist[1]);
`else
    assign samp = rx_s;
`endif
    assign hit = s_tick && tick == (state == START ? TW'(OVS / 2 - 1) : TW'(OVS - 1));
    assign last_stop = bcnt == BW'(SB - 1);
    assign ferr_f = ferr_n | ~samp;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {rx_m, rx_s} <= 2'b11;
            state        <= IDLE;
            tick         <= '0;
            bcnt         <= '0;
            data         <= '0;
            low_seen     <= 1'b0;
            par_acc      <= 1'b0;
            par_bit      <= 1'b0;
            perr_n       <= 1'b0;
            ferr_n       <= 1'b0;
            rx_dout      <= '0;
            rx_done_tick <= 1'b0;
            rx_valid     <= 1'b0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
            break_det    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            rx_m         <= rx;
            rx_s         <= rx_m;
            rx_done_tick <= 1'b0;
            if (rd && rx_valid) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end
            if (state != IDLE && s_tick) tick <= hit ? '0 : tick + 1'b1;
            case (state)
                IDLE:
                    if (low_seen) low_seen <= ~rx_s;
                    else if (!rx_s) begin
                        state <= START;
                        tick  <= '0;
                    end
                START:
                    if (hit) begin
                        bcnt    <= '0;
                        par_acc <= 1'b0;
                        par_bit <= 1'b0;
                        perr_n  <= 1'b0;
                        ferr_n  <= 1'b0;
                        state   <= samp ? IDLE : DATA;
                    end
                DATA:
                    if (hit) begin
                        data    <= {samp, data[DBIT-1:1]};
                        par_acc <= par_acc ^ samp;
                        bcnt    <= bcnt == BW'(DBIT - 1) ? '0 : bcnt + 1'b1;
                        if (bcnt == BW'(DBIT - 1)) state <= PARITY != 0 ? PAR : STOP;
                    end
                PAR:
                    if (hit) begin
                        par_bit <= samp;
                        perr_n  <= (par_acc ^ samp) != (PARITY == 1);
                        state   <= STOP;
                    end
                STOP:
                    if (hit) begin
                        if (last_stop) begin
                            // Leave at mid stop bit so the next start edge is caught early.
                            state        <= IDLE;
                            low_seen     <= ~samp;
                            rx_done_tick <= 1'b1;
                            rx_dout      <= data;
                            parity_err   <= perr_n;
                            frame_err    <= ferr_f;
                            break_det    <= ~|data & ~par_bit & ferr_f;
                            rx_valid     <= 1'b1;
                            overrun      <= rx_valid & ~rd;
                        end else begin
                            ferr_n <= ferr_f;
                            bcnt   <= bcnt + 1'b1;
                        end
                    end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
